// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain driver.
//  - REG_* : MAX7219 register addresses
//  - state_e : sequencing FSM states of the top level
//  - shift_phase_e : serializer phases of the shifter
//  - lowest_set() : picks the lowest-index dirty row
//  - init_word() : {addr,data} command for each step of the init sequence
package max7219_pkg;

  localparam logic [7:0] REG_NOP          = 8'h00;
  localparam logic [7:0] REG_DIGIT0       = 8'h01;
  localparam logic [7:0] REG_DECODE_MODE  = 8'h09;
  localparam logic [7:0] REG_INTENSITY    = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN     = 8'h0C;
  localparam logic [7:0] REG_DISPLAY_TEST = 8'h0F;

  // Index of the last of the five init commands.
  localparam logic [2:0] INIT_LAST = 3'd4;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef enum logic [2:0] {
    SH_IDLE,
    SH_LOW,
    SH_HIGH,
    SH_LATCH,
    SH_GAP
  } shift_phase_e;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    casez (v)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [15:0] init_word(input logic [2:0] idx,
                                            input logic [7:0] scan,
                                            input logic [7:0] decode,
                                            input logic [3:0] inten);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {REG_DISPLAY_TEST, 8'h00};
      3'd1:    w = {REG_SHUTDOWN, 8'h01};
      3'd2:    w = {REG_SCAN_LIMIT, scan};
      3'd3:    w = {REG_INTENSITY, 4'h0, inten};
      3'd4:    w = {REG_DECODE_MODE, decode};
      default: w = {REG_NOP, 8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/max7219_shifter.sv
// SPI serializer for one chain-wide MAX7219 transaction.
// Ports:
//  clk, reset     : clock, synchronous active-low reset
//  start, frame   : load N_DEV*16-bit frame (MSB first) when idle
//  spi_clk/dout/cs: serial pins (spi_clk idles low, cs active low)
//  busy           : cs fall until end of the inter-transaction gap
//  done           : one-cycle pulse at the end of the gap
module max7219_shifter
  import max7219_pkg::*;
#(
  parameter int N_DEV   = 4,
  parameter int CLK_DIV = 25,
  parameter int CS_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_DEV*16-1:0]  frame,
  output logic                 spi_clk,
  output logic                 dout,
  output logic                 cs,
  output logic                 busy,
  output logic                 done
);

  localparam int NBITS = N_DEV * 16;
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP * CLK_DIV - 1);

  shift_phase_e       phase_r, phase_nxt_s;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic [NBITS-1:0]   shift_r;
  logic               spi_clk_r, dout_r, cs_r, busy_r, done_r;
  logic               div_end_s;

  assign div_end_s = (div_cnt_r == DIV_LAST);

  // Phase register.
  always_ff @(posedge clk) begin
    if (!reset) phase_r <= SH_IDLE;
    else        phase_r <= phase_nxt_s;
  end

  // Next phase: each half-period lasts CLK_DIV clocks, gap lasts CS_GAP half-periods.
  always_comb begin
    phase_nxt_s = phase_r;
    case (phase_r)
      SH_IDLE:  if (start) phase_nxt_s = SH_LOW; else phase_nxt_s = SH_IDLE;
      SH_LOW:   if (div_end_s) phase_nxt_s = SH_HIGH; else phase_nxt_s = SH_LOW;
      SH_HIGH: begin
        if (div_end_s) begin
          if (bit_cnt_r == BIT_LAST) phase_nxt_s = SH_LATCH;
          else                       phase_nxt_s = SH_LOW;
        end else begin
          phase_nxt_s = SH_HIGH;
        end
      end
      SH_LATCH: if (div_end_s) phase_nxt_s = SH_GAP; else phase_nxt_s = SH_LATCH;
      SH_GAP:   if (gap_cnt_r == GAP_LAST) phase_nxt_s = SH_IDLE; else phase_nxt_s = SH_GAP;
      default:  phase_nxt_s = SH_IDLE;
    endcase
  end

  // Registered pin drivers, counters and shift register; dout changes only on entry to a low half.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      shift_r   <= '0;
      spi_clk_r <= 1'b0;
      dout_r    <= 1'b0;
      cs_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (phase_r)
        SH_IDLE: begin
          if (start) begin
            shift_r   <= frame;
            dout_r    <= frame[NBITS-1];
            cs_r      <= 1'b0;
            busy_r    <= 1'b1;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
          end
        end
        SH_LOW: begin
          if (div_end_s) begin
            spi_clk_r <= 1'b1;
            div_cnt_r <= '0;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        SH_HIGH: begin
          if (div_end_s) begin
            spi_clk_r <= 1'b0;
            div_cnt_r <= '0;
            if (bit_cnt_r != BIT_LAST) begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              shift_r   <= {shift_r[NBITS-2:0], 1'b0};
              dout_r    <= shift_r[NBITS-2];
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        SH_LATCH: begin
          if (div_end_s) begin
            cs_r      <= 1'b1;
            div_cnt_r <= '0;
            gap_cnt_r <= '0;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        SH_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign spi_clk = spi_clk_r;
  assign dout    = dout_r;
  assign cs      = cs_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: rtl/max7219_chain.sv
// MAX7219 daisy-chain driver: frame buffer, dirty-row refresh, runtime intensity.
// Ports:
//  clk, reset                       : clock, synchronous active-low reset
//  wr_en/wr_dev/wr_digit/wr_data    : frame buffer write (always accepted)
//  int_wr/int_val                   : request intensity update
//  spi_clk/dout/cs                  : chain SPI pins
//  busy, init_done                  : status
module max7219_chain
  import max7219_pkg::*;
#(
  parameter int         N_DEV      = 4,
  parameter int         CLK_DIV    = 25,
  parameter logic [7:0] SCAN_LIMIT = 8'd7,
  parameter logic [7:0] DECODE     = 8'hFF,
  parameter logic [3:0] INTENSITY  = 4'hF,
  parameter int         CS_GAP     = 4,
  localparam int        DEV_W      = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DEV_W-1:0] wr_dev,
  input  logic [2:0]       wr_digit,
  input  logic [7:0]       wr_data,
  input  logic             int_wr,
  input  logic [3:0]       int_val,
  output logic             spi_clk,
  output logic             dout,
  output logic             cs,
  output logic             busy,
  output logic             init_done
);

  state_e                      state_r, state_nxt_s;
  logic [2:0]                  init_idx_r;
  logic                        init_done_r;
  logic [N_DEV-1:0][7:0][7:0]  buf_r;
  logic [7:0]                  dirty_r;
  logic                        int_pend_r;
  logic [3:0]                  int_val_r;

  logic                        start_s, send_int_s, send_row_s, sh_done_s, wr_ok_s;
  logic [2:0]                  row_s;
  logic [7:0]                  clr_mask_s, set_mask_s;
  logic [N_DEV*16-1:0]         frame_s;

  // Qualify host writes: devices beyond the chain are dropped.
  always_comb begin
    if (wr_en && ({{(32-DEV_W){1'b0}}, wr_dev} < 32'(N_DEV))) wr_ok_s = 1'b1;
    else                                                       wr_ok_s = 1'b0;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= ST_RESET;
    else        state_r <= state_nxt_s;
  end

  // Sequencer next state: init commands, then serve intensity/dirty rows from idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RESET: state_nxt_s = ST_INIT;
      ST_INIT:  state_nxt_s = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (sh_done_s) begin
          if (init_idx_r == INIT_LAST) state_nxt_s = ST_IDLE;
          else                         state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_INIT_WAIT;
        end
      end
      ST_IDLE: begin
        if (int_pend_r || (dirty_r != 8'h00)) state_nxt_s = ST_WAIT;
        else                                  state_nxt_s = ST_IDLE;
      end
      ST_WAIT: if (sh_done_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_WAIT;
      default: state_nxt_s = ST_RESET;
    endcase
  end

  // Sequencer outputs: start strobe and frame; word for device 0 goes last (LSBs).
  always_comb begin
    start_s    = 1'b0;
    send_int_s = 1'b0;
    send_row_s = 1'b0;
    row_s      = lowest_set(dirty_r);
    frame_s    = '0;
    case (state_r)
      ST_INIT: begin
        start_s = 1'b1;
        for (int d = 0; d < N_DEV; d++)
          frame_s[d*16 +: 16] = init_word(init_idx_r, SCAN_LIMIT, DECODE, INTENSITY);
      end
      ST_IDLE: begin
        if (int_pend_r) begin
          start_s    = 1'b1;
          send_int_s = 1'b1;
          for (int d = 0; d < N_DEV; d++)
            frame_s[d*16 +: 16] = {REG_INTENSITY, 4'h0, int_val_r};
        end else if (dirty_r != 8'h00) begin
          start_s    = 1'b1;
          send_row_s = 1'b1;
          for (int d = 0; d < N_DEV; d++)
            frame_s[d*16 +: 16] = {REG_DIGIT0 + {5'b00000, row_s}, buf_r[d][row_s]};
        end else begin
          start_s = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Dirty-flag update masks; a write in the same cycle as a clear keeps the row dirty.
  always_comb begin
    if (send_row_s) clr_mask_s = 8'h01 << row_s;
    else            clr_mask_s = 8'h00;
    if (wr_ok_s)    set_mask_s = 8'h01 << wr_digit;
    else            set_mask_s = 8'h00;
  end

  // Init step counter and completion flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      init_idx_r  <= 3'd0;
      init_done_r <= 1'b0;
    end else if ((state_r == ST_INIT_WAIT) && sh_done_s) begin
      if (init_idx_r == INIT_LAST) init_done_r <= 1'b1;
      else                         init_idx_r  <= init_idx_r + 3'd1;
    end
  end

  // Frame buffer and dirty flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_r   <= '0;
      dirty_r <= 8'hFF;
    end else begin
      if (wr_ok_s) buf_r[wr_dev][wr_digit] <= wr_data;
      dirty_r <= (dirty_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Pending intensity: a new request always wins over the clear at send time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      int_pend_r <= 1'b0;
      int_val_r  <= 4'h0;
    end else if (int_wr) begin
      int_pend_r <= 1'b1;
      int_val_r  <= int_val;
    end else if (send_int_s) begin
      int_pend_r <= 1'b0;
    end
  end

  assign init_done = init_done_r;

  max7219_shifter #(
    .N_DEV   (N_DEV),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (start_s),
    .frame   (frame_s),
    .spi_clk (spi_clk),
    .dout    (dout),
    .cs      (cs),
    .busy    (busy),
    .done    (sh_done_s)
  );

endmodule

// File: tb/tb_max7219_chain.sv
// Self-checking bench for max7219_chain (N_DEV=2, CLK_DIV=2, CS_GAP=4).
// A pin-level monitor decodes transactions and checks SPI timing; scenario
// tasks compare decoded transactions with expectations built from a
// device-level model (frame buffer contents + sending order rules).
module tb_max7219_chain;

  localparam int N_DEV   = 2;
  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [0:0] wr_dev = 1'b0;
  logic [2:0] wr_digit = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       int_wr = 1'b0;
  logic [3:0] int_val = 4'h0;
  logic       spi_clk, dout, cs, busy, init_done;

  always #5 clk = ~clk;

  max7219_chain #(
    .N_DEV(N_DEV), .CLK_DIV(CLK_DIV), .SCAN_LIMIT(8'd7), .DECODE(8'hFF),
    .INTENSITY(4'hF), .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_dev(wr_dev), .wr_digit(wr_digit),
    .wr_data(wr_data), .int_wr(int_wr), .int_val(int_val), .spi_clk(spi_clk),
    .dout(dout), .cs(cs), .busy(busy), .init_done(init_done)
  );

  int checks = 0;
  int errors = 0;

  // Device-level model: what each display digit should hold.
  logic [7:0] mdl_buf [2][8];

  // Pin monitor state.
  logic [31:0] cap_q[$];
  int          capn_q[$];
  logic [31:0] cur_word = 32'h0;
  int          cur_bits = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          cs_high_cnt = 0;
  logic        prev_spi = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_dout = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (spi_clk === 1'b1 && prev_spi === 1'b0) begin
      checks++;
      if (dout !== prev_dout) begin
        errors++;
        $display("FAIL dout_stable: dout=%b at spi_clk rise, was %b one clk before", dout, prev_dout);
      end
      if (cur_bits > 0) begin
        checks++;
        if (cyc - last_rise != 2 * CLK_DIV) begin
          errors++;
          $display("FAIL spi_period: %0d clk between rises, required %0d", cyc - last_rise, 2 * CLK_DIV);
        end
      end
      last_rise = cyc;
      cur_word  = {cur_word[30:0], dout};
      cur_bits++;
    end
    if (cs === 1'b0 && prev_cs === 1'b1) begin
      checks++;
      if (cs_high_cnt < CS_GAP * CLK_DIV) begin
        errors++;
        $display("FAIL cs_gap: cs high %0d clk, required >= %0d", cs_high_cnt, CS_GAP * CLK_DIV);
      end
      cur_bits = 0;
      cur_word = 32'h0;
    end
    if (cs === 1'b1 && prev_cs === 1'b0) begin
      cap_q.push_back(cur_word);
      capn_q.push_back(cur_bits);
    end
    if (cs === 1'b1) cs_high_cnt++;
    else             cs_high_cnt = 0;
    prev_spi  = spi_clk;
    prev_cs   = cs;
    prev_dout = dout;
  end

  function automatic logic [31:0] row_txn(input int r);
    logic [7:0] a;
    a = 8'(r + 1);
    return {a, mdl_buf[1][r], a, mdl_buf[0][r]};
  endfunction

  task automatic wait_quiet(output bit ok);
    int quiet = 0;
    int n = 0;
    while (quiet < 24 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (busy === 1'b0 && cs === 1'b1) quiet++;
      else quiet = 0;
    end
    ok = (quiet >= 24);
  endtask

  task automatic wait_busy(output bit ok);
    int n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (busy === 1'b1);
  endtask

  task automatic do_write(input int dev, input int digit, input logic [7:0] data);
    wr_en = 1'b1; wr_dev = 1'(dev); wr_digit = 3'(digit); wr_data = data;
    mdl_buf[dev][digit] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 8; r++) mdl_buf[d][r] = 8'h00;
  endtask

  task automatic expect_init(ref logic [31:0] exp_q[$]);
    exp_q.push_back(32'h0F000F00);
    exp_q.push_back(32'h0C010C01);
    exp_q.push_back(32'h0B070B07);
    exp_q.push_back(32'h0A0F0A0F);
    exp_q.push_back(32'h09FF09FF);
    for (int r = 0; r < 8; r++) exp_q.push_back(row_txn(r));
  endtask

  task automatic test_reset();
    clear_model();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (cs !== 1'b1)      begin errors++; $display("FAIL reset_cs: got %b want 1", cs); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_spi_clk: got %b want 0", spi_clk); end
    checks++; if (dout !== 1'b0)    begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    cap_q.delete(); capn_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_init(input string tag);
    logic [31:0] exp_q[$];
    bit ok;
    expect_init(exp_q);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: DUT never went idle", tag); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL %s_done: init_done=%b want 1", tag, init_done); end
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d txns want %0d", tag, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i] || capn_q[i] != 32) begin
        errors++; $display("FAIL %s_txn%0d: got %h (%0d bits) want %h", tag, i, cap_q[i], capn_q[i], exp_q[i]);
      end
    end
    cap_q.delete(); capn_q.delete();
  endtask

  task automatic test_single_write();
    logic [31:0] exp_q[$];
    bit ok;
    do_write(1, 3, 8'h5A);
    exp_q.push_back(row_txn(3));
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: DUT never went idle"); end
    checks++; if (exp_q[0] !== 32'h045A0400) begin errors++; $display("FAIL single_model: model %h want 045A0400", exp_q[0]); end
    checks++; if (spi_clk !== 1'b0 || cs !== 1'b1) begin errors++; $display("FAIL single_idle_pins: spi_clk=%b cs=%b want 0/1", spi_clk, cs); end
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d txns want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i] || capn_q[i] != 32) begin
        errors++; $display("FAIL single_txn%0d: got %h (%0d bits) want %h", i, cap_q[i], capn_q[i], exp_q[i]);
      end
    end
    cap_q.delete(); capn_q.delete();
  endtask

  task automatic test_rewrite_mid();
    logic [31:0] exp_q[$];
    bit ok;
    do_write(1, 3, 8'h11);
    exp_q.push_back(row_txn(3));
    wait_busy(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_busy: busy=%b want 1", busy); end
    repeat (40) @(posedge clk);
    #1;
    do_write(1, 3, 8'h22);
    exp_q.push_back(row_txn(3));
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_timeout: DUT never went idle"); end
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL rewrite_count: got %0d txns want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i] || capn_q[i] != 32) begin
        errors++; $display("FAIL rewrite_txn%0d: got %h (%0d bits) want %h", i, cap_q[i], capn_q[i], exp_q[i]);
      end
    end
    cap_q.delete(); capn_q.delete();
  endtask

  task automatic test_int_coalesce();
    logic [31:0] exp_q[$];
    bit ok;
    do_write(0, 5, 8'($urandom));
    exp_q.push_back(row_txn(5));
    wait_busy(ok);
    checks++; if (!ok) begin errors++; $display("FAIL coalesce_busy: busy=%b want 1", busy); end
    int_wr = 1'b1; int_val = 4'd3;
    @(posedge clk); #1;
    int_val = 4'd9;
    @(posedge clk); #1;
    int_wr = 1'b0;
    exp_q.push_back(32'h0A090A09);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL coalesce_timeout: DUT never went idle"); end
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL coalesce_count: got %0d txns want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i] || capn_q[i] != 32) begin
        errors++; $display("FAIL coalesce_txn%0d: got %h (%0d bits) want %h", i, cap_q[i], capn_q[i], exp_q[i]);
      end
    end
    cap_q.delete(); capn_q.delete();
  endtask

  // From idle: the second request lands in the same cycle the first is sent.
  task automatic test_int_race();
    logic [31:0] exp_q[$];
    bit ok;
    int_wr = 1'b1; int_val = 4'd5;
    @(posedge clk); #1;
    int_val = 4'd7;
    @(posedge clk); #1;
    int_wr = 1'b0;
    exp_q.push_back(32'h0A050A05);
    exp_q.push_back(32'h0A070A07);
    wait_quiet(ok);
    checks++; if (!ok) begin errors++; $display("FAIL race_timeout: DUT never went idle"); end
    checks++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL race_count: got %0d txns want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i] || capn_q[i] != 32) begin
        errors++; $display("FAIL race_txn%0d: got %h (%0d bits) want %h", i, cap_q[i], capn_q[i], exp_q[i]);
      end
    end
    cap_q.delete(); capn_q.delete();
  endtask

  // Random writes during an intensity transaction: afterwards each touched
  // row goes out once, in ascending row order, with its final contents.
  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [7:0]  touched;
    logic [3:0]  v;
    bit ok;
    for (int round = 0; round < 4; round++) begin
      exp_q.delete();
      touched = 8'h00;
      v = 4'($urandom);
      int_wr = 1'b1; int_val = v;
      @(posedge clk); #1;
      int_wr = 1'b0;
      exp_q.push_back({8'h0A, 4'h0, v, 8'h0A, 4'h0, v});
      wait_busy(ok);
      checks++; if (!ok) begin errors++; $display("FAIL random%0d_busy: busy=%b want 1", round, busy); end
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
        int dg;
        dg = int'($urandom_range(7, 0));
        touched[dg] = 1'b1;
        do_write(int'($urandom_range(1, 0)), dg, 8'($urandom));
      end
      for (int r = 0; r < 8; r++)
        if (touched[r]) exp_q.push_back(row_txn(r));
      wait_quiet(ok);
      checks++; if (!ok) begin errors++; $display("FAIL random%0d_timeout: DUT never went idle", round); end
      checks++;
      if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL random%0d_count: got %0d txns want %0d", round, cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i] || capn_q[i] != 32) begin
          errors++; $display("FAIL random%0d_txn%0d: got %h (%0d bits) want %h", round, i, cap_q[i], capn_q[i], exp_q[i]);
        end
      end
      cap_q.delete(); capn_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_write(0, 0, 8'hC3);
    while (cur_bits < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cur_bits < 10) begin errors++; $display("FAIL rstmid_wait: reached %0d bits want 10", cur_bits); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cs !== 1'b1)      begin errors++; $display("FAIL rstmid_cs: got %b want 1", cs); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rstmid_spi_clk: got %b want 0", spi_clk); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rstmid_init_done: got %b want 0", init_done); end
    repeat (8) @(posedge clk);
    #1;
    clear_model();
    cap_q.delete(); capn_q.delete();
    reset = 1'b1;
    test_init("rstmid_init");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_single_write();
    test_rewrite_mid();
    test_int_coalesce();
    test_int_race();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
